// File: rtl/multicycle_control_unit.sv
// Main FSM sequencer for the multicycle RISC datapath: FETCH/DECODE/EXEC/MEM/WB,
// memory-ready stalls and a wrapping retired-instruction counter.
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             ext_op,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // Sign-extend for arithmetic, address and branch offsets; logical immediates zero-extend.
  function automatic logic sext_sel(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_LW, OP_SW, OP_BEQ: sext_sel = 1'b1;
      default: sext_sel = 1'b0;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_s;

  // State, latched opcode and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'h00;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, opcode capture and retire detection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode == OP_J) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else if (!is_legal(opcode)) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI, OP_ANDI, OP_ORI: state_d = S_WB;
          OP_LW, OP_SW:                   state_d = S_MEM;
          OP_BEQ: begin
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (op_q == OP_LW) begin
          state_d = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    if (retire_s) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else          cnt_d = cnt_q;
  end

  // Datapath controls; all forced low while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
          end else begin
            ir_write = 1'b0;
          end
        end
        S_DECODE: begin
          ext_op = sext_sel(opcode);
          if (opcode == OP_J) begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end else if (!is_legal(opcode)) begin
            illegal_op = 1'b1;
          end else begin
            pc_write = 1'b0;
          end
        end
        S_EXEC: begin
          ext_op = sext_sel(op_q);
          case (op_q)
            OP_R: alu_op = 2'b10;
            OP_ADDI, OP_LW, OP_SW: begin
              alu_src = 1'b1;
              alu_op  = 2'b00;
            end
            OP_ANDI, OP_ORI: begin
              alu_src = 1'b1;
              alu_op  = 2'b11;
            end
            OP_BEQ: begin
              alu_op   = 2'b01;
              pc_src   = 2'b01;
              pc_write = zero;
            end
            default: alu_op = 2'b00;
          endcase
        end
        S_MEM: begin
          if (op_q == OP_LW) mem_read = 1'b1;
          else               mem_write = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LW);
          reg_dst    = (op_q == OP_R);
        end
        default: pc_write = 1'b0;
      endcase
    end else begin
      pc_write = 1'b0;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instruction streams against a per-instruction
// cycle model; a second CNT_W=4 instance shares the stimulus to exercise counter wrap.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode;

  logic        pc_write, ir_write, ext_op, alu_src, reg_dst, reg_write;
  logic        mem_to_reg, mem_read, mem_write, illegal_op;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  state;
  logic [15:0] instr_count;

  logic        pc_write4, ir_write4, ext_op4, alu_src4, reg_dst4, reg_write4;
  logic        mem_to_reg4, mem_read4, mem_write4, illegal_op4;
  logic [1:0]  pc_src4, alu_op4;
  logic [2:0]  state4;
  logic [3:0]  instr_count4;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  multicycle_control_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .ext_op(ext_op),
    .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  multicycle_control_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write4), .pc_src(pc_src4), .ir_write(ir_write4), .ext_op(ext_op4),
    .alu_src(alu_src4), .alu_op(alu_op4), .reg_dst(reg_dst4), .reg_write(reg_write4),
    .mem_to_reg(mem_to_reg4), .mem_read(mem_read4), .mem_write(mem_write4),
    .illegal_op(illegal_op4), .state(state4), .instr_count(instr_count4)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {pc_write, pc_src, ir_write, ext_op, alu_src, alu_op, reg_dst,
                     reg_write, mem_to_reg, mem_read, mem_write, illegal_op, state};

  function automatic logic [16:0] mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                     input logic ext, input logic asrc, input logic [1:0] aop,
                                     input logic rdst, input logic rw, input logic m2r,
                                     input logic mr, input logic mw, input logic ill,
                                     input logic [2:0] st);
    return {pcw, pcs, irw, ext, asrc, aop, rdst, rw, m2r, mr, mw, ill, st};
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
           op == 6'h0C || op == 6'h0D || op == 6'h23 || op == 6'h2B;
  endfunction

  function automatic bit signext(input logic [5:0] op);
    return op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04;
  endfunction

  task automatic chk(input logic [16:0] exp, input string tag);
    #1;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (instr_count === 16'(exp_count)) else begin
      failures++;
      $error("FAIL %s_count observed=%0d expected=%0d", tag, instr_count, 16'(exp_count));
    end
    checks++;
    assert (instr_count4 === 4'(exp_count)) else begin
      failures++;
      $error("FAIL %s_count4 observed=%0d expected=%0d", tag, instr_count4, 4'(exp_count));
    end
  endtask

  task automatic cyc(input logic [16:0] exp, input string tag);
    chk(exp, tag);
    @(negedge clk);
  endtask

  // Runs one whole instruction; assumes entry at a negedge with the FSM in FETCH.
  task automatic do_instr(input logic [5:0] op, input logic z, input int fstall, input int mstall);
    bit is_lw, is_sw;
    is_lw = (op == 6'h23);
    is_sw = (op == 6'h2B);
    for (int i = 0; i < fstall; i++) begin
      mem_ready = 1'b0; opcode = 6'($urandom); zero = 1'($urandom);
      cyc(mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3'd0), "fetch_stall");
    end
    mem_ready = 1'b1; opcode = 6'($urandom); zero = 1'($urandom);
    cyc(mk(1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3'd0), "fetch");
    opcode = op; mem_ready = 1'($urandom); zero = 1'($urandom);
    cyc(mk(op == 6'h02, (op == 6'h02) ? 2'd2 : 2'd0, 0, signext(op), 0, 2'd0,
           0, 0, 0, 0, 0, !legal(op), 3'd1), "decode");
    if (op == 6'h02) begin exp_count++; return; end
    if (!legal(op)) return;
    // Scramble the live opcode: EXEC onward must use the latched one.
    opcode = 6'($urandom); zero = z; mem_ready = 1'($urandom);
    case (op)
      6'h00: cyc(mk(0, 2'd0, 0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 3'd2), "exec_r");
      6'h08: cyc(mk(0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), "exec_addi");
      6'h0C, 6'h0D: cyc(mk(0, 2'd0, 0, 0, 1, 2'd3, 0, 0, 0, 0, 0, 0, 3'd2), "exec_logic");
      6'h04: cyc(mk(z, 2'd1, 0, 1, 0, 2'd1, 0, 0, 0, 0, 0, 0, 3'd2), "exec_beq");
      default: cyc(mk(0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), "exec_mem");
    endcase
    if (op == 6'h04) begin exp_count++; return; end
    if (is_lw || is_sw) begin
      for (int i = 0; i <= mstall; i++) begin
        mem_ready = (i == mstall); opcode = 6'($urandom); zero = 1'($urandom);
        cyc(mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, is_lw, is_sw, 0, 3'd3), "mem");
      end
      if (is_sw) begin exp_count++; return; end
    end
    zero = 1'($urandom); mem_ready = 1'($urandom); opcode = 6'($urandom);
    cyc(mk(0, 2'd0, 0, 0, 0, 2'd0, op == 6'h00, 1, is_lw, 0, 0, 0, 3'd4), "wb");
    exp_count++;
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F, 6'h11};
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1; zero = 1'b0;
    @(negedge clk);
    cyc(17'h00000, "reset");
    rst_n = 1'b1;

    do_instr(6'h08, 1'b0, 0, 0);
    do_instr(6'h0D, 1'b0, 1, 0);
    do_instr(6'h0C, 1'b1, 0, 0);
    do_instr(6'h23, 1'b0, 0, 3);
    do_instr(6'h04, 1'b1, 0, 0);
    do_instr(6'h04, 1'b0, 0, 0);
    do_instr(6'h3F, 1'b0, 0, 0);
    do_instr(6'h02, 1'b0, 0, 0);
    do_instr(6'h00, 1'b0, 0, 0);
    do_instr(6'h2B, 1'b0, 0, 2);

    // SW interrupted by reset while stalled in MEM
    mem_ready = 1'b1;
    cyc(mk(1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 3'd0), "rst_fetch");
    opcode = 6'h2B;
    cyc(mk(0, 2'd0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3'd1), "rst_decode");
    cyc(mk(0, 2'd0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3'd2), "rst_exec");
    mem_ready = 1'b0;
    chk(mk(0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 3'd3), "rst_mem");
    #1 rst_n = 1'b0;
    exp_count = 0;
    chk(17'h00000, "rst_async");
    @(negedge clk);
    chk(17'h00000, "rst_held");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      do_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
